servo_pwm_decoder: RTL and testbench



---
 rtl/servo_pkg.sv | 15 +
 rtl/pwm_edge_sync.sv | 89 ++++++++
 rtl/servo_pwm_decoder.sv | 143 ++++++++++++++
 tb/tb_servo_pwm_decoder.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// Shared definitions for the gate servo PWM generator and decoder.
package servo_pkg;

    localparam int CNT_W     = 20;
    localparam int MIN_PULSE = 50000;
    localparam int MAX_PULSE = 100000;
    localparam int PERIOD    = 1000000;

    typedef enum logic [1:0] {
        S_SEEK,
        S_LOW,
        S_HIGH
    } dec_state_e;

endpackage

// File: rtl/pwm_edge_sync.sv
// Synchronizer, optional glitch filter (SERVO_DEC_GLITCH_FILTER_EN),
// and rise/fall strobes for the servo PWM line.
module pwm_edge_sync #(
    parameter int GLITCH_LEN = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall,
    output logic ready
);

`ifdef SERVO_DEC_GLITCH_FILTER_EN
    localparam int PRIME_N = 3 + GLITCH_LEN;
`else
    localparam int PRIME_N = 3;
`endif
    localparam int PW = $clog2(PRIME_N + 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          prev_q, prev_d;
    logic [PW-1:0] prime_q, prime_d;

`ifdef SERVO_DEC_GLITCH_FILTER_EN
    localparam int GW = $clog2(GLITCH_LEN + 1);

    logic          filt_q, filt_d;
    logic [GW-1:0] gcnt_q, gcnt_d;

    always_comb begin
        filt_d = filt_q;
        gcnt_d = '0;
        if (sync2_q != filt_q) begin
            if (gcnt_q == GW'(GLITCH_LEN - 1)) begin
                filt_d = sync2_q;
            end else begin
                gcnt_d = gcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q <= 1'b0;
            gcnt_q <= '0;
        end else begin
            filt_q <= filt_d;
            gcnt_q <= gcnt_d;
        end
    end

    assign level = filt_q;
`else
    assign level = sync2_q;
`endif

    // level is meaningless until the reset zeros have left the pipeline
    always_comb begin
        sync1_d = pin;
        sync2_d = sync1_q;
        prev_d  = level;
        prime_d = prime_q;
        if (prime_q != PW'(PRIME_N)) begin
            prime_d = prime_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            prime_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            prime_q <= prime_d;
        end
    end

    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;
    assign ready = (prime_q == PW'(PRIME_N));

endmodule

// File: rtl/servo_pwm_decoder.sv
// Servo PWM pulse-width decoder with hysteretic gate_open and signal_lost.
// Optional glitch filter: define SERVO_DEC_GLITCH_FILTER_EN.
module servo_pwm_decoder
    import servo_pkg::*;
#(
    parameter int CNT_W      = servo_pkg::CNT_W,
    parameter int MIN_PULSE  = servo_pkg::MIN_PULSE,
    parameter int MAX_PULSE  = servo_pkg::MAX_PULSE,
    parameter int PULSE_TOL  = 2500,
    parameter int OPEN_HI    = 90000,
    parameter int OPEN_LO    = 60000,
    parameter int TIMEOUT    = 1500000,
    parameter int GLITCH_LEN = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] width,
    output logic             width_valid,
    output logic             pulse_err,
    output logic             gate_open,
    output logic             signal_lost
);

    // timeout counter widens when TIMEOUT does not fit in CNT_W bits
    localparam int TO_NEED = $clog2(TIMEOUT + 1);
    localparam int TO_W    = (CNT_W > TO_NEED) ? CNT_W : TO_NEED;

    localparam logic [CNT_W-1:0] LO_LIM  = CNT_W'(MIN_PULSE - PULSE_TOL);
    localparam logic [CNT_W-1:0] HI_LIM  = CNT_W'(MAX_PULSE + PULSE_TOL);
    localparam logic [CNT_W-1:0] ERR_LIM = CNT_W'(MAX_PULSE + PULSE_TOL + 1);
    localparam logic [CNT_W-1:0] OPN_HI  = CNT_W'(OPEN_HI);
    localparam logic [CNT_W-1:0] OPN_LO  = CNT_W'(OPEN_LO);
    localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(TIMEOUT);

    logic level, rise, fall, ready;

    pwm_edge_sync #(
        .GLITCH_LEN(GLITCH_LEN)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .pin  (pwm_in),
        .level(level),
        .rise (rise),
        .fall (fall),
        .ready(ready)
    );

    dec_state_e       state_q, state_d;
    logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
    logic [CNT_W-1:0] width_q, width_d;
    logic             wv_q, wv_d;
    logic             err_q, err_d;
    logic             gate_q, gate_d;
    logic [TO_W-1:0]  to_q, to_d;

    always_comb begin
        state_d    = state_q;
        high_cnt_d = high_cnt_q;
        width_d    = width_q;
        wv_d       = 1'b0;
        err_d      = 1'b0;
        unique case (state_q)
            S_SEEK: begin
                if (ready && !level) begin
                    state_d = S_LOW;
                end
            end
            S_LOW: begin
                if (rise) begin
                    state_d    = S_HIGH;
                    high_cnt_d = CNT_W'(1);
                end
            end
            S_HIGH: begin
                if (fall) begin
                    state_d = S_LOW;
                    if (high_cnt_q >= LO_LIM && high_cnt_q <= HI_LIM) begin
                        width_d = high_cnt_q;
                        wv_d    = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (high_cnt_q == ERR_LIM) begin
                    err_d   = 1'b1;
                    state_d = S_SEEK;
                end else begin
                    high_cnt_d = high_cnt_q + 1'b1;
                end
            end
            default: state_d = S_SEEK;
        endcase
    end

    // a valid width always wins over timeout expiry in the same cycle
    always_comb begin
        to_d   = to_q;
        gate_d = gate_q;
        if (wv_d) begin
            to_d = '0;
        end else if (to_q != TO_MAX) begin
            to_d = to_q + 1'b1;
        end
        if (wv_d) begin
            if (width_d >= OPN_HI) begin
                gate_d = 1'b1;
            end else if (width_d <= OPN_LO) begin
                gate_d = 1'b0;
            end
        end
        if (to_d == TO_MAX) begin
            gate_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_SEEK;
            high_cnt_q <= '0;
            width_q    <= '0;
            wv_q       <= 1'b0;
            err_q      <= 1'b0;
            gate_q     <= 1'b0;
            to_q       <= '0;
        end else begin
            state_q    <= state_d;
            high_cnt_q <= high_cnt_d;
            width_q    <= width_d;
            wv_q       <= wv_d;
            err_q      <= err_d;
            gate_q     <= gate_d;
            to_q       <= to_d;
        end
    end

    assign width       = width_q;
    assign width_valid = wv_q;
    assign pulse_err   = err_q;
    assign gate_open   = gate_q;
    assign signal_lost = (to_q == TO_MAX);

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Scoreboard bench for servo_pwm_decoder using scaled-down timing parameters.
module tb_servo_pwm_decoder;

    localparam int CNT_W      = 12;
    localparam int MIN_PULSE  = 50;
    localparam int MAX_PULSE  = 100;
    localparam int PULSE_TOL  = 3;
    localparam int OPEN_HI    = 90;
    localparam int OPEN_LO    = 60;
    localparam int TIMEOUT    = 1500;
    localparam int GLITCH_LEN = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             pwm_in;
    logic [CNT_W-1:0] width;
    logic             width_valid;
    logic             pulse_err;
    logic             gate_open;
    logic             signal_lost;

    typedef struct {
        bit is_err;
        int w;
    } ev_t;

    ev_t sb[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  exp_w = 0;
    int  cyc = 0;
    int  last_valid_cyc = 0;

    servo_pwm_decoder #(
        .CNT_W     (CNT_W),
        .MIN_PULSE (MIN_PULSE),
        .MAX_PULSE (MAX_PULSE),
        .PULSE_TOL (PULSE_TOL),
        .OPEN_HI   (OPEN_HI),
        .OPEN_LO   (OPEN_LO),
        .TIMEOUT   (TIMEOUT),
        .GLITCH_LEN(GLITCH_LEN)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pwm_in     (pwm_in),
        .width      (width),
        .width_valid(width_valid),
        .pulse_err  (pulse_err),
        .gate_open  (gate_open),
        .signal_lost(signal_lost)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n === 1'b1 && (width_valid === 1'b1 || pulse_err === 1'b1)) begin
            ev_t e;
            n_cmp++;
            if (width_valid === 1'b1) last_valid_cyc = cyc;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_event: valid=%0b err=%0b width=%0d, required no event",
                         width_valid, pulse_err, width);
            end else begin
                e = sb.pop_front();
                if (pulse_err !== e.is_err || width_valid !== !e.is_err ||
                    width !== CNT_W'(e.w)) begin
                    n_bad++;
                    $display("FAIL event: err=%0b width=%0d, required err=%0b width=%0d",
                             pulse_err, width, e.is_err, e.w);
                end
            end
        end
    end

    task automatic expect_ok(input int w);
        sb.push_back('{1'b0, w});
        exp_w = w;
    endtask

    task automatic expect_err();
        sb.push_back('{1'b1, exp_w});
    endtask

    task automatic send_pulse(input int hi, input int lo);
        @(negedge clk);
        pwm_in = 1'b1;
        repeat (hi) @(negedge clk);
        pwm_in = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 3000 && sb.size() != 0; i++) @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL %s_drain: %0d events pending, required 0", tag, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        pwm_in = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (width !== '0 || width_valid !== 1'b0 || pulse_err !== 1'b0 ||
            gate_open !== 1'b0 || signal_lost !== 1'b0) begin
            n_bad++;
            $display("FAIL reset: w=%0d v=%0b e=%0b g=%0b l=%0b, required all 0",
                     width, width_valid, pulse_err, gate_open, signal_lost);
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_nominal();
        for (int i = 0; i < 3; i++) begin
            expect_ok(75);
            send_pulse(75, 925);
            n_cmp++;
            if (width !== CNT_W'(75) || gate_open !== 1'b0) begin
                n_bad++;
                $display("FAIL nominal_%0d: width=%0d gate=%0b, required 75 / 0",
                         i, width, gate_open);
            end
        end
        drain("nominal");
    endtask

    task automatic test_gate();
        int w[3] = '{95, 80, 55};
        bit g[3] = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            expect_ok(w[i]);
            send_pulse(w[i], 300);
            n_cmp++;
            if (gate_open !== g[i]) begin
                n_bad++;
                $display("FAIL gate_%0d: gate_open=%0b, required %0b", w[i], gate_open, g[i]);
            end
        end
        drain("gate");
    endtask

    task automatic test_errors();
        expect_err();
        send_pulse(30, 300);
        expect_err();
        send_pulse(200, 300);
        expect_ok(50);
        send_pulse(50, 300);
        drain("errors");
        n_cmp++;
        if (width !== CNT_W'(50)) begin
            n_bad++;
            $display("FAIL errors_recover: width=%0d, required 50", width);
        end
    endtask

    task automatic test_bounds();
        expect_ok(MIN_PULSE - PULSE_TOL);
        send_pulse(MIN_PULSE - PULSE_TOL, 300);
        expect_err();
        send_pulse(MIN_PULSE - PULSE_TOL - 1, 300);
        expect_ok(MAX_PULSE + PULSE_TOL);
        send_pulse(MAX_PULSE + PULSE_TOL, 300);
        expect_err();
        send_pulse(MAX_PULSE + PULSE_TOL + 1, 300);
        drain("bounds");
        n_cmp++;
        if (gate_open !== 1'b1 || width !== CNT_W'(MAX_PULSE + PULSE_TOL)) begin
            n_bad++;
            $display("FAIL bounds_hold: gate=%0b width=%0d, required 1 / %0d",
                     gate_open, width, MAX_PULSE + PULSE_TOL);
        end
    endtask

    task automatic test_timeout();
        int target;
        expect_ok(100);
        send_pulse(100, 10);
        drain("timeout_pulse");
        target = last_valid_cyc + TIMEOUT;
        while (cyc < target - 1) @(negedge clk);
        n_cmp++;
        if (signal_lost !== 1'b0 || gate_open !== 1'b1) begin
            n_bad++;
            $display("FAIL timeout_early: lost=%0b gate=%0b, required 0 / 1",
                     signal_lost, gate_open);
        end
        @(negedge clk);
        n_cmp++;
        if (signal_lost !== 1'b1 || gate_open !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_expiry: lost=%0b gate=%0b, required 1 / 0",
                     signal_lost, gate_open);
        end
        expect_ok(75);
        send_pulse(75, 300);
        drain("timeout_recover");
        n_cmp++;
        if (signal_lost !== 1'b0 || gate_open !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_recover: lost=%0b gate=%0b, required 0 / 0",
                     signal_lost, gate_open);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        pwm_in = 1'b1;
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (width !== '0 || width_valid !== 1'b0 || gate_open !== 1'b0 ||
            signal_lost !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid: w=%0d v=%0b g=%0b l=%0b, required all 0",
                     width, width_valid, gate_open, signal_lost);
        end
        sb.delete();
        exp_w = 0;
        rst_n = 1'b1;
        repeat (70) @(negedge clk);
        pwm_in = 1'b0;
        repeat (300) @(negedge clk);
        expect_ok(75);
        send_pulse(75, 300);
        drain("reset_mid");
        n_cmp++;
        if (width !== CNT_W'(75)) begin
            n_bad++;
            $display("FAIL reset_mid_next: width=%0d, required 75", width);
        end
    endtask

    task automatic test_glitch();
`ifdef SERVO_DEC_GLITCH_FILTER_EN
        expect_ok(90);
`else
        expect_err();
        expect_err();
`endif
        @(negedge clk);
        pwm_in = 1'b1;
        repeat (44) @(negedge clk);
        pwm_in = 1'b0;
        repeat (2) @(negedge clk);
        pwm_in = 1'b1;
        repeat (44) @(negedge clk);
        pwm_in = 1'b0;
        repeat (300) @(negedge clk);
        drain("glitch");
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_gate();
        test_errors();
        test_bounds();
        test_timeout();
        test_reset_mid();
        test_glitch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
